// File: rtl/mips32_fetch_queue.sv
//==============================================================================
// mips32_fetch_queue : instruction prefetch queue ahead of the IF/ID latch
// Optional perf counters via FQ_PERF_CNT_EN.  Rev 1.0
//==============================================================================
`default_nettype none

module mips32_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW = 10,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  input  logic          halt,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [31:0]   inst_word,
  output logic [31:0]   inst_npc
`ifdef FQ_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetched,
  output logic [15:0]   perf_flushed
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Drop counter has headroom for several back-to-back redirects in flight.
  localparam int DW = PW + 4;

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] resp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [DW-1:0] drop;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          active;

  logic [31:0]   word_mem [DEPTH];
  logic [AW-1:0] npc_mem  [DEPTH];

  logic [CW:0]   in_use;
  logic          handshake;
  logic          take;
  logic          push;
  logic          pop;
  logic          drop_dec;
  logic          flush_dec;

  assign in_use    = {1'b0, count} + {1'b0, outstanding};
  // active keeps the request line low while in reset and for the first cycle after
  assign imem_req  = active && !halt && !redirect_valid && (in_use < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign handshake = imem_req && imem_ready;

  assign take      = imem_rvalid && (drop == '0) && (outstanding != '0);
  assign push      = take && !redirect_valid;
  assign pop       = inst_valid && inst_ready && !redirect_valid;
  assign drop_dec  = imem_rvalid && (drop != '0);
  assign flush_dec = imem_rvalid && ((drop != '0) || (outstanding != '0));

  assign inst_valid = (count != '0);
  assign inst_word  = inst_valid ? word_mem[rd_ptr] : 32'd0;
  assign inst_npc   = inst_valid ? {{(32-AW){1'b0}}, npc_mem[rd_ptr]} : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      active      <= 1'b0;
    end else begin
      active <= 1'b1;
      if (redirect_valid) begin
        count       <= '0;
        rd_ptr      <= wr_ptr;
        fetch_pc    <= redirect_pc;
        resp_pc     <= redirect_pc;
        outstanding <= '0;
        drop        <= drop + DW'(outstanding) - DW'(flush_dec);
      end else begin
        if (handshake) fetch_pc <= fetch_pc + AW'(1);
        outstanding <= outstanding + CW'(handshake) - CW'(take);
        drop        <= drop - DW'(drop_dec);
        if (push) begin
          resp_pc <= resp_pc + AW'(1);
          wr_ptr  <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr] <= imem_rdata;
      npc_mem[wr_ptr]  <= resp_pc + AW'(1);
    end
  end

`ifdef FQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (push && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
      if (redirect_valid && (perf_flushed != '1)) perf_flushed <= perf_flushed + 16'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_orphan_resp : assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> ((drop != '0) || (outstanding != '0)));
`endif

endmodule

`default_nettype wire
